// File: rtl/scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : scan_mux
// Description : Channel multiplexer with manual select or auto round-robin
//               scan. A prescaler paces the scan. Data, index and one-hot
//               channel enable are registered.
//               Optional feature: define SCAN_MUX_BLANK_EN to force CH_EN low
//               for BLANK_CYC cycles after every index change.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_mux #(
  parameter int WIDTH     = 5,
  parameter int CHANNELS  = 4,
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 2,
  localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          CONTROL,
  input  logic [CHANNELS*WIDTH-1:0] IN,
  output logic [WIDTH-1:0]          OUT,
  output logic [SEL_W-1:0]          SEL_OUT,
  output logic [CHANNELS-1:0]       CH_EN,
  output logic                      WRAP
);

  // Dead-time length; zero removes the blanking logic entirely.
`ifdef SCAN_MUX_BLANK_EN
  localparam int BLANK_LEN = BLANK_CYC;
`else
  localparam int BLANK_LEN = 0 * BLANK_CYC;
`endif

  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [CHANNELS-1:0] ch_en_q, ch_en_d;
  logic                wrap_q, wrap_d;
  logic                w_tick;
  logic                w_cur_valid;
  logic [CHANNELS-1:0] w_onehot;

  // Prescaler, next index and data/enable decode of the next index.
  always_comb begin
    w_tick = (cnt_q == CNT_LAST);
    cnt_d  = w_tick ? '0 : cnt_q + CNT_W'(1);

    // An index can be out of range only after a manual CONTROL >= CHANNELS.
    w_cur_valid = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_q == SEL_W'(k)) w_cur_valid = 1'b1;
    end

    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (!MODE) begin
      sel_d = CONTROL;
    end else if (w_tick) begin
      if (!w_cur_valid) begin
        // Recover into the scan without claiming a wrap.
        sel_d = '0;
      end else if (sel_q == SEL_LAST) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end

    // Out-of-range indices match no channel: data and enable stay zero.
    out_d    = '0;
    w_onehot = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_d == SEL_W'(k)) begin
        out_d       = IN[k*WIDTH +: WIDTH];
        w_onehot[k] = 1'b1;
      end
    end
  end

  generate
    if (BLANK_LEN > 0) begin : g_blank
      localparam int BLK_W = $clog2(BLANK_LEN + 1);
      logic [BLK_W-1:0] blank_q, blank_d;
      logic             w_change;

      // Dead-time counter: the change edge itself is the first blank cycle,
      // and any further change restarts the window.
      always_comb begin
        w_change = (sel_d != sel_q);
        if (w_change) begin
          blank_d = BLK_W'(BLANK_LEN - 1);
        end else if (blank_q != '0) begin
          blank_d = blank_q - BLK_W'(1);
        end else begin
          blank_d = '0;
        end
        ch_en_d = (w_change || (blank_q != '0)) ? '0 : w_onehot;
      end

      // Blank counter register; reset clears any pending dead time.
      always_ff @(posedge CLK) begin
        if (RESET) blank_q <= '0;
        else       blank_q <= blank_d;
      end
    end else begin : g_no_blank
      // Enable follows the new index immediately.
      always_comb begin
        ch_en_d = w_onehot;
      end
    end
  endgenerate

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      ch_en_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      ch_en_q <= ch_en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign OUT     = out_q;
  assign SEL_OUT = sel_q;
  assign CH_EN   = ch_en_q;
  assign WRAP    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_mux
// Description : Self-checking bench for scan_mux (WIDTH=5, CHANNELS=4, DIV=4,
//               BLANK_CYC=2). Honours SCAN_MUX_BLANK_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux;

  localparam int W  = 5;
  localparam int CH = 4;
  localparam int DV = 4;
  localparam int BC = 2;
  localparam int SW = 2;
`ifdef SCAN_MUX_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mode = 1'b0;
  logic [SW-1:0]     control = '0;
  logic [CH*W-1:0]   in_bus = '0;
  logic [W-1:0]      out_w;
  logic [SW-1:0]     sel_out;
  logic [CH-1:0]     ch_en;
  logic              wrap;

  int errors = 0;
  int checks = 0;

  scan_mux #(.WIDTH(W), .CHANNELS(CH), .DIV(DV), .BLANK_CYC(BC)) dut (
    .CLK(clk), .RESET(reset), .MODE(mode), .CONTROL(control), .IN(in_bus),
    .OUT(out_w), .SEL_OUT(sel_out), .CH_EN(ch_en), .WRAP(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: ticks fall on every DIV-th edge after reset release.
  int           n_edges = 0;
  int           m_idx   = 0;
  int           m_since = 1000;
  logic [W-1:0] m_out   = '0;
  logic [CH-1:0] m_chen = '0;
  logic         m_wrap  = 1'b0;

  always @(posedge clk) begin
    int nxt;
    if (reset) begin
      n_edges = 0; m_idx = 0; m_since = 1000;
      m_out = '0; m_chen = '0; m_wrap = 1'b0;
    end else begin
      n_edges++;
      nxt    = m_idx;
      m_wrap = 1'b0;
      if (!mode) nxt = int'(control);
      else if (n_edges % DV == 0) begin
        if (m_idx >= CH) nxt = 0;
        else begin
          nxt    = (m_idx + 1) % CH;
          m_wrap = (nxt == 0);
        end
      end
      if (nxt != m_idx) m_since = 0;
      else if (m_since < 1000) m_since++;
      m_idx  = nxt;
      m_out  = '0;
      m_chen = '0;
      if (nxt < CH) begin
        m_out       = in_bus[nxt*W +: W];
        m_chen[nxt] = 1'b1;
      end
      if (BLANK_ON && m_since < BC) m_chen = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic md);
    reset = 1'b1; mode = md; control = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [SW-1:0] exp_sel;
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    reset = 1'b1; mode = 1'b1; control = '0;
    repeat (3) begin
      step();
      checks++;
      if (out_w !== '0 || ch_en !== '0 || sel_out !== '0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: out=%0d ch_en=%b sel=%0d wrap=%b, required 0/0000/0/0",
                 out_w, ch_en, sel_out, wrap);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp_sel = (c == 4) ? 2'd1 : 2'd0;
      checks++;
      if (sel_out !== exp_sel) begin
        errors++;
        $display("FAIL first_advance c=%0d: sel=%0d, required %0d", c, sel_out, exp_sel);
      end
    end
  endtask

  task automatic test_auto_scan();
    logic [W-1:0]  tbl [4] = '{5'd3, 5'd21, 5'd10, 5'd31};
    logic [CH-1:0] exp_en;
    int k;
    int wrap_cnt = 0;
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    do_reset(1'b1);
    for (int c = 1; c <= 20; c++) begin
      step();
      wrap_cnt += int'(wrap);
      checks++;
      if (sel_out !== SW'(m_idx) || out_w !== m_out || ch_en !== m_chen || wrap !== m_wrap) begin
        errors++;
        $display("FAIL auto_model c=%0d: sel=%0d out=%0d en=%b wrap=%b, required %0d/%0d/%b/%b",
                 c, sel_out, out_w, ch_en, wrap, m_idx, m_out, m_chen, m_wrap);
      end
      if (c % 4 == 0) begin
        k = (c / 4) % 4;
        exp_en = BLANK_ON ? 4'b0000 : 4'(1 << k);
        checks++;
        if (sel_out !== SW'(k) || out_w !== tbl[k] || ch_en !== exp_en || wrap !== (k == 0)) begin
          errors++;
          $display("FAIL auto_step c=%0d: sel=%0d out=%0d en=%b wrap=%b, required %0d/%0d/%b/%b",
                   c, sel_out, out_w, ch_en, wrap, k, tbl[k], exp_en, (k == 0));
        end
      end
    end
    checks++;
    if (wrap_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_count: %0d pulses, required 1", wrap_cnt);
    end
  endtask

  task automatic test_manual();
    logic [CH-1:0] exp_en;
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    do_reset(1'b0);
    control = 2'd2;
    step();
    exp_en = BLANK_ON ? 4'b0000 : 4'b0100;
    checks++;
    if (out_w !== 5'd10 || sel_out !== 2'd2 || ch_en !== exp_en) begin
      errors++;
      $display("FAIL manual_select: out=%0d sel=%0d en=%b, required 10/2/%b", out_w, sel_out, ch_en, exp_en);
    end
    repeat (2) step();
    checks++;
    if (ch_en !== 4'b0100) begin
      errors++;
      $display("FAIL manual_enable: en=%b, required 0100", ch_en);
    end
    in_bus[2*W +: W] = 5'd7;
    step();
    checks++;
    if (out_w !== 5'd7) begin
      errors++;
      $display("FAIL manual_track_in: out=%0d, required 7", out_w);
    end
    // Successive CONTROL changes: blanking must restart on each change.
    control = 2'd1; step();
    control = 2'd3;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (sel_out !== SW'(m_idx) || out_w !== m_out || ch_en !== m_chen || wrap !== 1'b0) begin
        errors++;
        $display("FAIL manual_restart c=%0d: sel=%0d out=%0d en=%b wrap=%b, required %0d/%0d/%b/0",
                 c, sel_out, out_w, ch_en, wrap, m_idx, m_out, m_chen);
      end
    end
  endtask

  task automatic test_mode_switch();
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    do_reset(1'b0);
    control = 2'd1;
    repeat (2) step();
    mode = 1'b1; control = 2'd3;
    step();
    checks++;
    if (sel_out !== 2'd1) begin
      errors++;
      $display("FAIL switch_hold: sel=%0d, required 1", sel_out);
    end
    step();
    checks++;
    if (sel_out !== 2'd2 || out_w !== 5'd10) begin
      errors++;
      $display("FAIL switch_tick: sel=%0d out=%0d, required 2/10", sel_out, out_w);
    end
    repeat (4) step();
    checks++;
    if (sel_out !== 2'd3) begin
      errors++;
      $display("FAIL switch_no_restart: sel=%0d, required 3", sel_out);
    end
  endtask

  task automatic test_blanking();
    logic [CH-1:0] exp_en;
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    do_reset(1'b1);
    repeat (3) step();
    for (int c = 0; c < 3; c++) begin
      step();
      exp_en = (BLANK_ON && c < 2) ? 4'b0000 : 4'b0010;
      checks++;
      if (out_w !== 5'd21 || sel_out !== 2'd1 || ch_en !== exp_en) begin
        errors++;
        $display("FAIL blank c=%0d: out=%0d sel=%0d en=%b, required 21/1/%b", c, out_w, sel_out, ch_en, exp_en);
      end
    end
  endtask

  task automatic test_reset_mid_blank();
    in_bus = {5'd31, 5'd10, 5'd21, 5'd3};
    do_reset(1'b1);
    repeat (4) step();
    reset = 1'b1;
    step();
    checks++;
    if (out_w !== '0 || ch_en !== '0 || sel_out !== '0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_blank: out=%0d en=%b sel=%0d wrap=%b, required 0/0000/0/0", out_w, ch_en, sel_out, wrap);
    end
    reset = 1'b0;
    step();
    checks++;
    if (ch_en !== 4'b0001 || sel_out !== 2'd0 || out_w !== 5'd3) begin
      errors++;
      $display("FAIL post_reset_no_blank: en=%b sel=%0d out=%0d, required 0001/0/3", ch_en, sel_out, out_w);
    end
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) control = SW'($urandom);
      if ($urandom_range(0, 2) == 0) in_bus = (CH*W)'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      step();
      checks++;
      if (sel_out !== SW'(m_idx) || out_w !== m_out || ch_en !== m_chen || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random c=%0d: sel=%0d out=%0d en=%b wrap=%b, required %0d/%0d/%b/%b",
                 c, sel_out, out_w, ch_en, wrap, m_idx, m_out, m_chen, m_wrap);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_manual();
    test_mode_switch();
    test_blanking();
    test_reset_mid_blank();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the bit width of each data channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, legal 2..16, meaning the number of input channels.
REQ-003 The block SHALL have parameter DIV, default 100000, legal >=2, meaning the clock cycles per auto-scan step.
REQ-004 The block SHALL have parameter BLANK_CYC, default 2, legal 1..DIV-1, meaning the dead-time length in cycles (used only under REQ-026).
REQ-005 The block SHALL have localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-006 The block SHALL have port CLK  input  1  meaning system clock; all logic on its rising edge.
REQ-007 The block SHALL have port RESET  input  1  meaning synchronous, active-high reset.
REQ-008 The block SHALL have port MODE  input  1  meaning 0 = manual select, 1 = auto round-robin scan.
REQ-009 The block SHALL have port CONTROL  input  SEL_W  meaning the channel select in manual mode.
REQ-010 The block SHALL have port IN  input  CHANNELS*WIDTH  meaning flattened data, channel k = IN[k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port OUT  output  WIDTH  meaning the registered data of the selected channel.
REQ-012 The block SHALL have port SEL_OUT  output  SEL_W  meaning the registered current channel index.
REQ-013 The block SHALL have port CH_EN  output  CHANNELS  meaning the registered one-hot active-high enable of the current channel.
REQ-014 The block SHALL have port WRAP  output  1  meaning a one-cycle pulse when the auto scan wraps from CHANNELS-1 to 0.

Function
REQ-015 The prescaler SHALL count 0..DIV-1 and restart at 0 in both modes; TICK = (count == DIV-1).
REQ-016 In auto mode, on a TICK cycle the index SHALL advance by 1, wrapping CHANNELS-1 -> 0; with no TICK it SHALL hold.
REQ-017 WRAP SHALL be 1 for exactly the cycle after the wrap edge; otherwise 0, and always 0 in manual mode.
REQ-018 In manual mode the index SHALL load CONTROL every cycle, giving 1-cycle latency from CONTROL to all outputs.
REQ-019 An out-of-range CONTROL (>= CHANNELS) SHALL produce SEL_OUT = CONTROL, OUT = 0 and CH_EN = 0.
REQ-020 OUT, SEL_OUT and CH_EN SHALL update on the same edge: OUT = IN slice of the new index, CH_EN = 1 << new index.
REQ-021 OUT SHALL track IN changes with 1-cycle latency even when the index does not change.
REQ-022 A manual-to-auto switch SHALL continue scanning from the current index without resetting the prescaler; an auto-to-manual switch SHALL load CONTROL on the next edge.
REQ-023 If MODE becomes 1 while the index is out of range, the next TICK SHALL load index 0, WRAP SHALL stay 0, and the index SHALL hold until that TICK.

Reset
REQ-024 While RESET = 1 at an edge: prescaler = 0, index = 0, OUT = 0, SEL_OUT = 0, CH_EN = 0, WRAP = 0.
REQ-025 RESET SHALL override all inputs, including mid-scan and mid-blank; the first post-reset TICK SHALL occur DIV cycles after release.

Configuration
REQ-026 With SCAN_MUX_BLANK_EN defined, every index change SHALL force CH_EN = 0 for BLANK_CYC cycles, then assert the new one-hot; OUT and SEL_OUT SHALL update without delay.
REQ-027 Without SCAN_MUX_BLANK_EN, CH_EN SHALL follow REQ-020 with no dead time and BLANK_CYC SHALL be ignored.
REQ-028 In manual mode with SCAN_MUX_BLANK_EN defined, a CONTROL change SHALL trigger the same blanking, and a change during blanking SHALL restart the BLANK_CYC count.

Verification (WIDTH=5, CHANNELS=4, DIV=4, BLANK_CYC=2)
REQ-029 The bench SHALL check reset: RESET held 3 cycles with IN=0x1F_0A_15_03 -> OUT=0, CH_EN=0000, SEL_OUT=0; the first index advance 4 cycles after release.
REQ-030 The bench SHALL check auto scan: MODE=1, IN channels {3,21,10,31} -> SEL_OUT 0,1,2,3,0 every 4 cycles, OUT 3,21,10,31,3, CH_EN 0001..1000, and WRAP high for exactly one cycle at 3->0.
REQ-031 The bench SHALL check manual select: MODE=0, CONTROL=2 -> next edge OUT=10, CH_EN=0100; change IN channel 2 to 7 -> OUT=7 one cycle later.
REQ-032 The bench SHALL check mode switching: switch manual (CONTROL=1) to auto mid-prescale -> index 1 holds until the pending TICK, then goes to 2 with no prescaler restart.
REQ-033 The bench SHALL check blanking: with SCAN_MUX_BLANK_EN, auto step 0->1 -> CH_EN=0000 for 2 cycles then 0010, OUT=21 immediately; without the macro, CH_EN=0010 on the step edge.
REQ-034 The bench SHALL check reset mid-blank: RESET asserted during the blank window -> all outputs 0 on the next edge, with no residual blank after release.
